// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC and fetch-buffer stage feeding decode from a combinational ROM
//
// Purpose: holds the program counter, addresses the instruction ROM, registers
// the returned word together with its PC and presents it to decode with a
// valid flag. Accepts redirects from execute, parks issue while an ECALL is
// being serviced, and locks into a sticky fault on a bad PC.
//
// Parameters:
//   RESET_PC    - PC loaded on reset
//   ROM_ADDR_W  - ROM word-address width
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   rom_addr_o        - ROM word address, pc[ROM_ADDR_W+1:2] (combinational)
//   rom_data_i        - ROM word for rom_addr_o (combinational)
//   stall_i           - decode not ready: hold fetch buffer and PC
//   redirect_i        - load PC from redirect_pc_i (flushes the buffer)
//   redirect_pc_i     - branch / jump target
//   instr_o           - registered instruction
//   instr_pc_o        - PC of instr_o
//   instr_valid_o     - instr_o is a live issue
//   ecall_req_o       - ECALL service request
//   ecall_ack_i       - ECALL service complete
//   fault_o           - sticky fault flag
//   fault_cause_o     - 00 none, 01 misaligned redirect, 10 PC out of ROM range
//   fetch_count_o     - issued-instruction counter (wraps)
//
// Build option:
//   FETCH_RANGE_CHECK_EN - when defined, a PC or redirect target with any bit
//   set above the ROM window faults with cause 10. When undefined, the ROM
//   address aliases and the high PC bits simply pass through to instr_pc_o.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ROM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]           rom_data_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic [31:0]           instr_o,
    output logic [31:0]           instr_pc_o,
    output logic                  instr_valid_o,
    output logic                  ecall_req_o,
    input  logic                  ecall_ack_i,
    output logic                  fault_o,
    output logic [1:0]            fault_cause_o,
    output logic [31:0]           fetch_count_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_ECALL_WAIT = 2'd1,
        ST_FAULT      = 2'd2
    } state_t;

    localparam logic [31:0] ECALL_WORD     = 32'h0000_0073;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE    = 2'b10;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        valid_d;
    logic        req_q;
    logic        req_d;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [1:0]  cause_d;
    logic [31:0] count_q;

    logic        redir_misalign;
    logic        redir_out_of_range;
    logic        redir_bad;
    logic        pc_out_of_range;
    logic        is_ecall_word;

    logic        issue;
    logic        load_redirect;
    logic        enter_fault;
    logic        ack_take;

    // ------------------------------------------------------------------
    // Target / PC qualification
    // ------------------------------------------------------------------
    always_comb begin
        redir_misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHECK_EN
        redir_out_of_range = redirect_i && (redirect_pc_i[31:ROM_ADDR_W+2] != '0);
        pc_out_of_range    = (pc_q[31:ROM_ADDR_W+2] != '0);
`else
        redir_out_of_range = 1'b0;
        pc_out_of_range    = 1'b0;
`endif
        redir_bad     = redir_misalign || redir_out_of_range;
        is_ecall_word = (rom_data_i == ECALL_WORD);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    // A good redirect keeps the state; stall is irrelevant here.
                    if (redir_bad) begin
                        state_d = ST_FAULT;
                    end
                end else if (!stall_i) begin
                    if (pc_out_of_range) begin
                        state_d = ST_FAULT;
                    end else if (is_ecall_word) begin
                        state_d = ST_ECALL_WAIT;
                    end
                end
            end
            ST_ECALL_WAIT: begin
                // The ack is honoured even alongside a stall or good redirect.
                if (redirect_i && redir_bad) begin
                    state_d = ST_FAULT;
                end else if (ecall_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output decode
    // ------------------------------------------------------------------
    always_comb begin
        issue         = (state_q == ST_RUN) && !redirect_i && !stall_i && !pc_out_of_range;
        load_redirect = (state_q != ST_FAULT) && redirect_i && !redir_bad;
        enter_fault   = (state_q != ST_FAULT) && (state_d == ST_FAULT);
        ack_take      = (state_q == ST_ECALL_WAIT) && ecall_ack_i && !enter_fault;

        // Misalignment is the stronger diagnosis when both apply.
        cause_d = redir_misalign ? CAUSE_MISALIGN : CAUSE_RANGE;

        valid_d = valid_q;
        if ((state_q == ST_FAULT) || enter_fault) begin
            valid_d = 1'b0;
        end else if (load_redirect) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (issue) begin
            valid_d = 1'b1;
        end else begin
            // ECALL_WAIT with nothing else going on: no live issue.
            valid_d = 1'b0;
        end

        req_d = req_q;
        if ((state_q == ST_FAULT) || enter_fault) begin
            req_d = 1'b0;
        end else if (ack_take) begin
            req_d = 1'b0;
        end else if (issue && is_ecall_word) begin
            req_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= 2'b00;
            count_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;

            if (load_redirect) begin
                pc_q <= redirect_pc_i;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end

            if (issue) begin
                instr_q    <= rom_data_i;
                instr_pc_q <= pc_q;
                count_q    <= count_q + 32'd1;
            end

            // Only the first cause is recorded; FAULT never re-enters.
            if (enter_fault) begin
                fault_q <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    assign rom_addr_o    = pc_q[ROM_ADDR_W+1:2];
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign ecall_req_o   = req_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit against a behavioural fetch model
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          AW       = 10;
`ifdef FETCH_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam int MR = 0;  // running
    localparam int MW = 1;  // waiting for ECALL service
    localparam int MF = 2;  // faulted

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          ecall_req;
    logic          ecall_ack;
    logic          fault;
    logic [1:0]    fault_cause;
    logic [31:0]   fetch_count;

    logic [31:0]   rom [0:(1<<AW)-1];
    assign rom_data = rom[rom_addr];

    instr_fetch_unit #(.RESET_PC(RESET_PC), .ROM_ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .ecall_req_o   (ecall_req),
        .ecall_ack_i   (ecall_ack),
        .fault_o       (fault),
        .fault_cause_o (fault_cause),
        .fetch_count_o (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [31:0]   instr;
        logic [31:0]   ipc;
        logic          req;
        logic          fault;
        logic [1:0]    cause;
        logic [31:0]   count;
        logic [AW-1:0] rom_addr;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state: what the fetch stage should look like after each edge.
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_req;
    logic        m_fault;
    logic [1:0]  m_cause;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every negedge the DUT presents one output snapshot; compare it
    // with the oldest prediction.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, " valid"},    {31'b0, instr_valid}, {31'b0, e.valid});
            chk({t, " instr"},    instr,                e.instr);
            chk({t, " instr_pc"}, instr_pc,             e.ipc);
            chk({t, " ecall_req"},{31'b0, ecall_req},   {31'b0, e.req});
            chk({t, " fault"},    {31'b0, fault},       {31'b0, e.fault});
            chk({t, " cause"},    {30'b0, fault_cause}, {30'b0, e.cause});
            chk({t, " count"},    fetch_count,          e.count);
            chk({t, " rom_addr"}, {22'b0, rom_addr},    {22'b0, e.rom_addr});
        end
    end

    function automatic logic out_of_rom(input logic [31:0] a);
        return RANGE_EN && (a >= (32'd4 << AW));
    endfunction

    task automatic go_fault(input logic [1:0] c);
        m_mode  = MF;
        m_fault = 1'b1;
        m_cause = c;
        m_valid = 1'b0;
        m_req   = 1'b0;
    endtask

    // One clock of the fetch stage described by its rules.
    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ak, input logic rs);
        logic [31:0] w;
        logic        ack_ok;
        if (rs) begin
            m_pc = RESET_PC; m_mode = MR; m_instr = 0; m_ipc = 0; m_valid = 0;
            m_req = 0; m_fault = 0; m_cause = 0; m_count = 0;
        end else if (m_mode == MF) begin
            m_valid = 0;
            m_req   = 0;
        end else begin
            ack_ok = (m_mode == MW) && ak;
            if (rd) begin
                if (rpc % 4 != 0)          go_fault(2'b01);
                else if (out_of_rom(rpc))  go_fault(2'b10);
                else begin
                    m_pc    = rpc;
                    m_valid = 0;
                end
            end else if (!st) begin
                if (m_mode == MR) begin
                    if (out_of_rom(m_pc)) begin
                        go_fault(2'b10);
                    end else begin
                        w       = rom[(m_pc / 4) % (1 << AW)];
                        m_instr = w;
                        m_ipc   = m_pc;
                        m_valid = 1;
                        m_pc    = m_pc + 4;
                        m_count = m_count + 1;
                        if (w == 32'h73) begin
                            m_mode = MW;
                            m_req  = 1;
                        end
                    end
                end else begin
                    m_valid = 0;
                end
            end
            if (ack_ok && m_mode == MW) begin
                m_mode = MR;
                m_req  = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic ak, input logic rs);
        exp_t e;
        rst_n       = !rs;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        ecall_ack   = ak;
        model_step(st, rd, rpc, ak, rs);
        e.valid    = m_valid;
        e.instr    = m_instr;
        e.ipc      = m_ipc;
        e.req      = m_req;
        e.fault    = m_fault;
        e.cause    = m_cause;
        e.count    = m_count;
        e.rom_addr = m_pc[AW+1:2];
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] tgt;
        int          r;

        for (int i = 0; i < (1 << AW); i++) begin
            w = $urandom();
            while (w == 32'h73) w = $urandom();
            rom[i] = w;
        end
        rom[0]   = 32'h0010_0093;
        rom[1]   = 32'h0100_006F;
        rom[18]  = 32'h0010_0013;
        rom[23]  = 32'h0000_0073;
        rom[150] = 32'h0000_0073;
        rom[400] = 32'h0000_0073;
        rom[777] = 32'h0000_0073;

        // Reset and sequential issue
        step("reset", 0, 0, 32'h0, 0, 1);
        run("seq", 2);
        // Stall holds everything, then issue resumes at pc 8
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 32'h0, 0, 0);
        run("resume", 1);
        // Redirect overriding stall, then issue of the target
        step("redir_flush", 1, 1, 32'h48, 0, 0);
        run("redir_issue", 1);
        // Run up to the ECALL at 0x5C, hold five cycles, then ack
        run("to_ecall", 5);
        run("ecall_hold", 5);
        step("ecall_ack", 0, 0, 32'h0, 1, 0);
        run("post_ecall", 2);
        step("ack_in_run", 0, 0, 32'h0, 1, 0);
        // Misaligned redirect and terminal fault
        step("misalign", 0, 1, 32'h102, 0, 0);
        step("fault_redir", 0, 1, 32'h20, 1, 0);
        step("fault_ack", 0, 0, 32'h0, 1, 0);
        run("fault_hold", 2);
        step("reset2", 0, 0, 32'h0, 0, 1);
        run("restart", 2);
        // Range: fault with the check, aliasing without it
        step("range_redir", 0, 1, 32'h1000, 0, 0);
        run("range_issue", 2);
        step("reset3", 0, 0, 32'h0, 0, 1);

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            if (m_mode == MF && $urandom_range(0, 2) == 0) begin
                step("rnd_reset", 0, 0, 32'h0, 0, 1);
            end else begin
                r   = $urandom_range(0, 99);
                tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                if (r < 2)       tgt = tgt | 32'($urandom_range(1, 3));
                else if (r < 6)  tgt = {$urandom()} & 32'hFFFF_FFFC;
                step("random",
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) == 0),
                     tgt,
                     ($urandom_range(0, 9) < 3),
                     1'b0);
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and fetch-buffer stage for the single-cycle RISC-V core. It drives the word address of the combinational instruction ROM, registers the returned word with its PC, and hands it to decode through a valid/stall interface. It takes branch and jump redirects from execute, holds issue during an ECALL service handshake, and raises a sticky fault on a bad PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `ROM_ADDR_W`, default 10: ROM word-address width (1024 words, 4 KB).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rom_addr_o` out ROM_ADDR_W: combinational, equals `pc[ROM_ADDR_W+1:2]`.
- `rom_data_i` in 32: ROM word, combinational from `rom_addr_o`.
- `stall_i` in 1: decode is not ready, so hold the fetch buffer and the PC.
- `redirect_i` in 1: load the PC from `redirect_pc_i`.
- `redirect_pc_i` in 32: branch or jump target.
- `instr_o` out 32: registered instruction.
- `instr_pc_o` out 32: PC of `instr_o`.
- `instr_valid_o` out 1: `instr_o` is a live issue.
- `ecall_req_o` out 1: ECALL service request.
- `ecall_ack_i` in 1: service done.
- `fault_o` out 1: sticky fault.
- `fault_cause_o` out 2: 00 none, 01 misaligned redirect, 10 PC out of ROM range.
- `fetch_count_o` out 32: count of issued instructions, wraps modulo 2^32.

## Operation
- States: RUN, ECALL_WAIT, FAULT.
- Reset (asynchronous) sets:
  - pc = RESET_PC, state RUN.
  - instr_o = 0, instr_pc_o = 0, instr_valid_o = 0.
  - ecall_req_o = 0, fault_o = 0, fault_cause_o = 00, fetch_count_o = 0.
- Per-edge priority in RUN and ECALL_WAIT:
  1. **Redirect.** If redirect_i is high:
     - Misaligned target (`redirect_pc_i[1:0] != 0`): go to FAULT with cause 01; the PC is not loaded.
     - Otherwise: pc <= redirect_pc_i, instr_valid_o <= 0 (flush), and the state is unchanged.
     - Redirect overrides stall_i.
  2. **Stall.** Else if stall_i is high: all registers hold.
  3. **Issue.** Else, in RUN only:
     - instr_o <= rom_data_i, instr_pc_o <= pc, instr_valid_o <= 1.
     - pc <= pc + 4 (32-bit, wraps).
     - fetch_count_o increments.
     - If rom_data_i == 32'h0000_0073 (ECALL): go to ECALL_WAIT and set ecall_req_o <= 1.
  4. **Hold in ECALL_WAIT.** Else, in ECALL_WAIT: instr_valid_o <= 0 and the PC holds.
- ecall_ack_i is sampled only in ECALL_WAIT. It forces ecall_req_o <= 0 and a return to RUN. Ack outside ECALL_WAIT is ignored.
  - Redirect and ack in the same cycle: both take effect.
  - Stall and ack in the same cycle: the ack still takes effect.
- FAULT is terminal until reset:
  - instr_valid_o <= 0, ecall_req_o <= 0, fault_o = 1.
  - fault_cause_o holds the first cause.
  - All inputs are ignored.

## Timing
- The ROM path is combinational within the cycle. The issued word appears at instr_o one edge after the PC that addressed it.
- Throughput is 1 instruction per cycle when there is no stall, redirect or ECALL.
- Redirect-to-issue latency is 2 edges: 1 flush edge, then the issue of the target word.
- ECALL sequence:
  - ecall_req_o rises on the same edge that issues the ECALL.
  - The first issue after the ack is on the edge following the ack edge, at ECALL PC + 4.
- Fault is flagged on the edge that detects it. That edge produces no issue.

## Configuration
- `FETCH_RANGE_CHECK_EN` defined:
  - Before an issue, if `pc[31:ROM_ADDR_W+2] != 0`, go to FAULT with cause 10 and do not issue.
  - The same check applies to a redirect target, which faults immediately with cause 10.
  - Misalignment (cause 01) takes precedence over range (cause 10).
- Macro undefined:
  - No range check; cause 10 never occurs.
  - rom_addr_o aliases modulo 4 KB, and the high PC bits pass through to instr_pc_o.

## Test plan
- **Sequential issue.** ROM word 0 = 32'h0010_0093, word 1 = 32'h0100_006F. Release reset with no stall. Required:
  - Edge 1: instr_pc_o = 0, instr_o = 32'h0010_0093, valid = 1.
  - Edge 2: instr_pc_o = 4, instr_o = 32'h0100_006F.
  - fetch_count_o = 2.
- **Stall.** Hold stall_i high for 3 cycles after edge 2. instr_o, instr_pc_o, pc and fetch_count_o are unchanged. Issue resumes at pc 8 when stall_i drops.
- **Redirect.** Drive redirect_i with redirect_pc_i = 32'h48 in the same cycle as stall_i. Required:
  - Next edge: valid = 0.
  - Following edge: instr_pc_o = 32'h48, instr_o = word 18 (32'h0010_0013).
- **ECALL.** ROM word 23 = 32'h73 at pc 32'h5C. Required:
  - After its issue: ecall_req_o = 1, and valid = 0 for 5 held cycles.
  - Pulse ecall_ack_i: ecall_req_o falls, then the next issue has pc 32'h60.
- **Misaligned redirect.** Drive redirect_pc_i = 32'h102. Required:
  - fault_o = 1, fault_cause_o = 01, valid stays 0, and further redirects and acks are ignored.
  - Asserting rst_n low clears everything and restarts at RESET_PC.
- **Range check.** Drive redirect_pc_i = 32'h1000. Required:
  - With FETCH_RANGE_CHECK_EN: fault with cause 10.
  - Without it: issue with instr_pc_o = 32'h1000, rom_addr_o = 0, instr_o = word 0.
